ifetch: RTL and testbench

Instruction fetch unit and byte prefetch queue for the f8 core. It sits directly upstream of the memory subsystem's instruction port. It drives `iread_addr` and consumes the 3-byte `iread_data`/`iread_valid` response. It presents a little-endian window of the next 3 instruction bytes to the decoder, which consumes 0–3 bytes per cycle. The decoder can redirect fetch on jumps, calls and interrupts.

---
 rtl/ifetch.sv | 98 +++++++++
 tb/tb_ifetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch unit: issues 3-byte fetches, buffers them in a circular
// byte queue and presents the next 3 bytes (little-endian) to the decoder.
module ifetch #(
    parameter int unsigned QUEUEBYTES  = 8,
    parameter logic [15:0] RESETVECTOR = 16'h4000
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [15:0]                   iread_addr,
    input  logic [23:0]                   iread_data,
    input  logic                          iread_valid,
    input  logic                          redirect,
    input  logic [15:0]                   redirect_addr,
    input  logic [1:0]                    consume,
    output logic [23:0]                   inst_bytes,
    output logic [$clog2(QUEUEBYTES):0]   inst_count,
    output logic [15:0]                   inst_pc
);
    localparam int unsigned PW = $clog2(QUEUEBYTES);
    localparam int unsigned CW = PW + 1;
    // Fetch only if a new 3-byte response is guaranteed to fit.
    localparam logic [CW:0] ISSUE_MAX = (CW+1)'(QUEUEBYTES - 3);

    logic [7:0]    mem [QUEUEBYTES];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] consume_eff;
    logic [CW:0]   in_use;
    logic [15:0]   fetch_addr;
    logic [15:0]   resp_addr;
    logic [15:0]   pc;
    logic          live;
    logic          append;
    logic          replay;
    logic          issue;

    assign tail        = head + PW'(count);
    assign consume_eff = (CW'(consume) > count) ? count : CW'(consume);
    assign in_use      = {1'b0, count} + (live ? (CW+1)'(3) : (CW+1)'(0));
    assign append      = !reset && !redirect && live && iread_valid;
    assign replay      = live && !iread_valid;
    assign issue       = !reset && !redirect && !replay && (in_use <= ISSUE_MAX);

    // Control state: redirect flushes everything; a dropped response rewinds fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            count      <= '0;
            live       <= 1'b0;
            fetch_addr <= RESETVECTOR;
            resp_addr  <= RESETVECTOR;
            pc         <= RESETVECTOR;
        end else if (redirect) begin
            count      <= '0;
            live       <= 1'b0;
            fetch_addr <= redirect_addr;
            pc         <= redirect_addr;
        end else begin
            head  <= head + PW'(consume_eff);
            count <= count - consume_eff + (append ? CW'(3) : CW'(0));
            pc    <= pc + 16'(consume_eff);
            if (replay) begin
                fetch_addr <= resp_addr;
                live       <= 1'b0;
            end else if (issue) begin
                live       <= 1'b1;
                resp_addr  <= fetch_addr;
                fetch_addr <= fetch_addr + 16'd3;
            end else begin
                live <= 1'b0;
            end
        end
    end

    // Queue storage needs no reset; lanes beyond count are masked on output.
    always_ff @(posedge clk) begin
        if (append) begin
            for (int k = 0; k < 3; k++) begin
                mem[tail + PW'(k)] <= iread_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        inst_bytes = '0;
        for (int k = 0; k < 3; k++) begin
            if (CW'(k) < count) begin
                inst_bytes[8*k +: 8] = mem[head + PW'(k)];
            end
        end
    end

    assign iread_addr = fetch_addr;
    assign inst_count = count;
    assign inst_pc    = pc;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: memory byte at A is A[7:0]; expectations are queued
// with each stimulus step and compared after the following clock edge.
module tb_ifetch;
    localparam int SEL_ADDR   = 0;
    localparam int SEL_CNT    = 1;
    localparam int SEL_BYTES  = 2;
    localparam int SEL_PC     = 3;
    localparam int SEL_LANE0  = 4;
    localparam int SEL_CNT_W  = 5;
    localparam int SEL_BYTES_W = 6;
    localparam int SEL_PC_W   = 7;
    localparam int SEL_VIOL   = 8;

    logic        clk;
    logic        reset;
    logic        iread_valid;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic [1:0]  consume;
    logic [1:0]  consume_w;

    logic [15:0] iread_addr,  iread_addr_w;
    logic [23:0] iread_data,  iread_data_w;
    logic [23:0] inst_bytes,  inst_bytes_w;
    logic [3:0]  inst_count;
    logic [4:0]  inst_count_w;
    logic [15:0] inst_pc,     inst_pc_w;

    int passed = 0;
    int total  = 0;
    int viol_cnt = 0;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;
    exp_t sb[$];

    ifetch #(.QUEUEBYTES(8), .RESETVECTOR(16'h4000)) dut (
        .clk(clk), .reset(reset),
        .iread_addr(iread_addr), .iread_data(iread_data), .iread_valid(iread_valid),
        .redirect(redirect), .redirect_addr(redirect_addr), .consume(consume),
        .inst_bytes(inst_bytes), .inst_count(inst_count), .inst_pc(inst_pc)
    );

    // Deeper queue instance: the only one that can sustain 3 bytes every cycle.
    ifetch #(.QUEUEBYTES(16), .RESETVECTOR(16'h4000)) dut_w (
        .clk(clk), .reset(reset),
        .iread_addr(iread_addr_w), .iread_data(iread_data_w), .iread_valid(iread_valid),
        .redirect(redirect), .redirect_addr(redirect_addr), .consume(consume_w),
        .inst_bytes(inst_bytes_w), .inst_count(inst_count_w), .inst_pc(inst_pc_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mem_word(input logic [15:0] a);
        logic [15:0] a1;
        logic [15:0] a2;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        return {a2[7:0], a1[7:0], a[7:0]};
    endfunction

    // Memory answers one cycle after the address is presented.
    always @(posedge clk) begin
        iread_data   <= mem_word(iread_addr);
        iread_data_w <= mem_word(iread_addr_w);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Decoder protocol: consume may not exceed the bytes actually available.
    always @(negedge clk) begin
        int avail;
        avail = (inst_count < 4'd3) ? int'(inst_count) : 3;
        if (reset === 1'b0 && redirect === 1'b0 && int'(consume) > avail) begin
            viol_cnt++;
            $display("protocol violation flagged: consume=%0d available=%0d", consume, avail);
        end
    end

    // Lanes past the valid count must read as zero.
    always @(negedge clk) begin
        if (reset === 1'b0 && inst_count < 4'd3)
            chk("lane2_zero", 32'(inst_bytes[23:16]), 32'h0);
        if (reset === 1'b0 && inst_count < 4'd2)
            chk("lane1_zero", 32'(inst_bytes[15:8]), 32'h0);
    end

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_ADDR:    return 32'(iread_addr);
            SEL_CNT:     return 32'(inst_count);
            SEL_BYTES:   return 32'(inst_bytes);
            SEL_PC:      return 32'(inst_pc);
            SEL_LANE0:   return 32'(inst_bytes[7:0]);
            SEL_CNT_W:   return 32'(inst_count_w);
            SEL_BYTES_W: return 32'(inst_bytes_w);
            SEL_PC_W:    return 32'(inst_pc_w);
            SEL_VIOL:    return 32'(viol_cnt);
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input int sel, input string tag, input logic [31:0] v);
        exp_t e;
        e.sel = sel;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic step();
        tick();
        drain();
    endtask

    initial begin
        logic [15:0] mpc;
        reset = 1'b1; redirect = 1'b0; redirect_addr = '0;
        consume = '0; consume_w = '0; iread_valid = 1'b1;
        tick(); tick();

        // Reset values
        expect_val(SEL_ADDR,  "rst_addr",  32'h4000);
        expect_val(SEL_CNT,   "rst_count", 32'd0);
        expect_val(SEL_BYTES, "rst_bytes", 32'h0);
        expect_val(SEL_PC,    "rst_pc",    32'h4000);
        drain();

        // Reset fetch: one request per cycle, then stop at 6 bytes
        reset = 1'b0;
        expect_val(SEL_ADDR, "t1_addr_r1", 32'h4003); step();
        expect_val(SEL_ADDR, "t1_addr_r2", 32'h4006);
        expect_val(SEL_CNT,  "t1_cnt_r2",  32'd3);
        expect_val(SEL_BYTES, "t1_bytes_r2", 32'h020100); step();
        step();
        expect_val(SEL_CNT,  "t1_cnt_full", 32'd6);
        expect_val(SEL_ADDR, "t1_addr_stop", 32'h4006);
        expect_val(SEL_BYTES, "t1_bytes_full", 32'h020100); step();

        // Stall and replay of the 4003 response
        reset = 1'b1; tick(); reset = 1'b0;
        expect_val(SEL_ADDR, "t2_addr_r1", 32'h4003); step();
        step();
        iread_valid = 1'b0;
        expect_val(SEL_ADDR, "t2_replay_addr", 32'h4003);
        expect_val(SEL_CNT,  "t2_cnt_r3", 32'd3); step();
        iread_valid = 1'b1; step();
        expect_val(SEL_CNT,   "t2_cnt_r5",   32'd6);
        expect_val(SEL_BYTES, "t2_bytes_r5", 32'h020100); step();
        consume = 2'd3;
        expect_val(SEL_CNT,   "t2_cnt_r6",   32'd3);
        expect_val(SEL_PC,    "t2_pc_r6",    32'h4003);
        expect_val(SEL_BYTES, "t2_bytes_r6", 32'h050403); step();
        consume = 2'd0;

        // Full throughput on the deep-queue instance
        reset = 1'b1; tick(); reset = 1'b0;
        step();
        expect_val(SEL_CNT_W, "t3_cnt_start", 32'd3); step();
        consume_w = 2'd3;
        mpc = 16'h4000;
        for (int k = 0; k < 6; k++) begin
            mpc = mpc + 16'd3;
            expect_val(SEL_PC_W,    "t3_pc",    32'(mpc));
            expect_val(SEL_CNT_W,   "t3_cnt",   32'd3);
            expect_val(SEL_BYTES_W, "t3_bytes", 32'(mem_word(mpc)));
            step();
        end
        consume_w = 2'd0;

        // Redirect with a live response and consume = 2
        reset = 1'b1; tick(); reset = 1'b0;
        step(); step();
        redirect = 1'b1; redirect_addr = 16'h4100; consume = 2'd2;
        expect_val(SEL_CNT,  "t4_cnt_n1",  32'd0);
        expect_val(SEL_PC,   "t4_pc_n1",   32'h4100);
        expect_val(SEL_ADDR, "t4_addr_n1", 32'h4100); step();
        redirect = 1'b0; consume = 2'd0;
        expect_val(SEL_ADDR, "t4_addr_n2", 32'h4103); step();
        expect_val(SEL_CNT,   "t4_cnt_n3",   32'd3);
        expect_val(SEL_PC,    "t4_pc_n3",    32'h4100);
        expect_val(SEL_BYTES, "t4_bytes_n3", 32'h020100); step();

        // Address wrap through FFFF -> 0000
        redirect = 1'b1; redirect_addr = 16'hFFFE;
        expect_val(SEL_ADDR, "t5_addr_m1", 32'hFFFE);
        expect_val(SEL_PC,   "t5_pc_m1",   32'hFFFE); step();
        redirect = 1'b0;
        expect_val(SEL_ADDR, "t5_addr_m2", 32'h0001); step();
        expect_val(SEL_CNT,   "t5_cnt_m3",   32'd3);
        expect_val(SEL_BYTES, "t5_bytes_m3", 32'h00FFFE); step();
        mpc = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            consume = 2'd1;
            mpc = mpc + 16'd1;
            expect_val(SEL_PC,    "t5_pc",    32'(mpc));
            expect_val(SEL_LANE0, "t5_lane0", 32'(mpc[7:0]));
            if (k == 2) expect_val(SEL_CNT, "t5_cnt_m6", 32'd6);
            step();
        end

        // Partial window and consume clamp
        iread_valid = 1'b0; consume = 2'd3;
        expect_val(SEL_CNT, "t6_cnt_a", 32'd3);
        expect_val(SEL_PC,  "t6_pc_a",  32'h0004); step();
        consume = 2'd1;
        expect_val(SEL_CNT,   "t6_cnt_two",   32'd2);
        expect_val(SEL_PC,    "t6_pc_b",      32'h0005);
        expect_val(SEL_BYTES, "t6_bytes_two", 32'h000605); step();
        consume = 2'd3;
        expect_val(SEL_VIOL,  "t6_violation", 32'd1);
        expect_val(SEL_CNT,   "t6_cnt_clamp", 32'd0);
        expect_val(SEL_PC,    "t6_pc_clamp",  32'h0007);
        expect_val(SEL_BYTES, "t6_bytes_empty", 32'h0); step();
        consume = 2'd0; iread_valid = 1'b1;
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
